// File: rtl/uid_tag_map_if.sv
// Bundle of the allocate, lookup and release signals shared by the ordering
// stage, the R-return path and the UID tag map.
interface uid_tag_map_if #(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned NUM_UIDS  = 16,
    parameter int unsigned CNT_WIDTH = $clog2(NUM_UIDS + 1)
);
    logic                 alloc_req;
    logic [ID_WIDTH-1:0]  alloc_in_id;
    logic                 alloc_gnt;
    logic [ID_WIDTH-1:0]  unique_id;
    logic                 tag_map_full;
    logic [ID_WIDTH-1:0]  lookup_uid;
    logic [ID_WIDTH-1:0]  lookup_orig_id;
    logic                 lookup_hit;
    logic                 rel_valid;
    logic [ID_WIDTH-1:0]  rel_uid;
    logic [CNT_WIDTH-1:0] occupancy;
    logic                 err_bad_release;

    modport master (
        output alloc_req, alloc_in_id, lookup_uid, rel_valid, rel_uid,
        input  alloc_gnt, unique_id, tag_map_full, lookup_orig_id, lookup_hit,
               occupancy, err_bad_release
    );

    modport slave (
        input  alloc_req, alloc_in_id, lookup_uid, rel_valid, rel_uid,
        output alloc_gnt, unique_id, tag_map_full, lookup_orig_id, lookup_hit,
               occupancy, err_bad_release
    );
endinterface

// File: rtl/uid_tag_map.sv
// UID allocator and tag map: grants the lowest free UID, remembers the original
// AXI ID per UID, maps R-beat UIDs back and frees them on the last beat.
module uid_tag_map #(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned NUM_UIDS  = 16,
    parameter int unsigned CNT_WIDTH = $clog2(NUM_UIDS + 1)
) (
    input logic          clk,
    input logic          rst,
    uid_tag_map_if.slave bus
);

    logic [NUM_UIDS-1:0]  alloc_bitmap_q, alloc_bitmap_d;
    logic [ID_WIDTH-1:0]  orig_tbl_q [NUM_UIDS];
    logic [CNT_WIDTH-1:0] occupancy_q, occupancy_d;
    logic                 err_q;

    logic                 full;
    logic                 gnt;
    logic                 free_found;
    logic [ID_WIDTH-1:0]  free_idx;
    logic [NUM_UIDS-1:0]  gnt_mask;
    logic [NUM_UIDS-1:0]  rel_mask;
    logic [NUM_UIDS-1:0]  lookup_mask;
    logic                 rel_ok;
    logic [ID_WIDTH-1:0]  lookup_id;

    assign full = (occupancy_q == CNT_WIDTH'(NUM_UIDS));
    assign gnt  = bus.alloc_req & ~full & ~rst;

    // Decoding via per-slot masks keeps every index inside 0..NUM_UIDS-1, so
    // out-of-range UIDs simply match nothing.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        gnt_mask    = '0;
        rel_mask    = '0;
        lookup_mask = '0;
        lookup_id   = '0;
        for (int i = 0; i < int'(NUM_UIDS); i++) begin
            if (!free_found && !alloc_bitmap_q[i]) begin
                free_found = 1'b1;
                free_idx   = ID_WIDTH'(i);
            end
            rel_mask[i]    = bus.rel_valid && (bus.rel_uid == ID_WIDTH'(i));
            lookup_mask[i] = (bus.lookup_uid == ID_WIDTH'(i));
            if (lookup_mask[i]) begin
                lookup_id = orig_tbl_q[i];
            end
        end
        for (int i = 0; i < int'(NUM_UIDS); i++) begin
            gnt_mask[i] = gnt && (free_idx == ID_WIDTH'(i));
        end
    end

    // Grant comes from the pre-release bitmap, so a UID freed this cycle is
    // never handed out again in the same cycle.
    always_comb begin
        rel_ok         = |(rel_mask & alloc_bitmap_q);
        alloc_bitmap_d = (alloc_bitmap_q | gnt_mask) & ~(rel_mask & alloc_bitmap_q);
        occupancy_d    = occupancy_q + CNT_WIDTH'(gnt) - CNT_WIDTH'(rel_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_bitmap_q <= '0;
            occupancy_q    <= '0;
            err_q          <= 1'b0;
            for (int i = 0; i < int'(NUM_UIDS); i++) begin
                orig_tbl_q[i] <= '0;
            end
        end else begin
            alloc_bitmap_q <= alloc_bitmap_d;
            occupancy_q    <= occupancy_d;
            err_q          <= bus.rel_valid & ~rel_ok;
            for (int i = 0; i < int'(NUM_UIDS); i++) begin
                if (gnt_mask[i]) begin
                    orig_tbl_q[i] <= bus.alloc_in_id;
                end
            end
        end
    end

    assign bus.alloc_gnt       = gnt;
    assign bus.unique_id       = free_idx;
    assign bus.tag_map_full    = full;
    assign bus.lookup_orig_id  = lookup_id;
    assign bus.lookup_hit      = |(lookup_mask & alloc_bitmap_q);
    assign bus.occupancy       = occupancy_q;
    assign bus.err_bad_release = err_q;

endmodule
